// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the cpu_multicycle core.
//   - opcode values and instruction field positions
//   - ALU operation and FSM state enumerations
//   - decode_op(): maps an opcode to its datapath controls
// The shift opcodes (08..0B) decode as real instructions only when the
// CPU_SHIFT_EN macro is defined; otherwise they fall through to NOP.
package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_SLL   = 8'h08;
  localparam logic [7:0] OP_SRL   = 8'h09;
  localparam logic [7:0] OP_SRA   = 8'h0A;
  localparam logic [7:0] OP_ROR   = 8'h0B;

  // Instruction word fields, each FIELD_W bits wide.
  localparam int FIELD_W  = 8;
  localparam int OPC_LSB  = 24;
  localparam int DST_LSB  = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 0;

  typedef enum logic [2:0] {
    ALU_FWD = 3'd0,
    ALU_ADD = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SHL = 3'd4,
    ALU_SHR = 3'd5,
    ALU_SRA = 3'd6,
    ALU_ROR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    sub;      // negate operand b before the adder
    logic    use_imm;  // operand b is the zero-extended immediate
    logic    wr;       // instruction writes the register file
    logic    jump;     // unconditional relative jump
    logic    branch;   // relative branch when operands are equal
  } dec_t;

  function automatic dec_t decode_op(input logic [7:0] opc);
    dec_t d;
    d.alu_op  = ALU_FWD;
    d.sub     = 1'b0;
    d.use_imm = 1'b0;
    d.wr      = 1'b0;
    d.jump    = 1'b0;
    d.branch  = 1'b0;
    case (opc)
      OP_LOADI: begin d.wr = 1'b1; d.use_imm = 1'b1; end
      OP_MOV:   begin d.wr = 1'b1; end
      OP_ADD:   begin d.wr = 1'b1; d.alu_op = ALU_ADD; end
      OP_SUB:   begin d.wr = 1'b1; d.alu_op = ALU_ADD; d.sub = 1'b1; end
      OP_AND:   begin d.wr = 1'b1; d.alu_op = ALU_AND; end
      OP_OR:    begin d.wr = 1'b1; d.alu_op = ALU_OR; end
      OP_J:     begin d.jump = 1'b1; end
      OP_BEQ:   begin d.branch = 1'b1; end
`ifdef CPU_SHIFT_EN
      OP_SLL:   begin d.wr = 1'b1; d.use_imm = 1'b1; d.alu_op = ALU_SHL; end
      OP_SRL:   begin d.wr = 1'b1; d.use_imm = 1'b1; d.alu_op = ALU_SHR; end
      OP_SRA:   begin d.wr = 1'b1; d.use_imm = 1'b1; d.alu_op = ALU_SRA; end
      OP_ROR:   begin d.wr = 1'b1; d.use_imm = 1'b1; d.alu_op = ALU_ROR; end
`endif
      default:  begin d.wr = 1'b0; end  // unknown opcode: NOP
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cpu_regfile_p.sv
// cpu_regfile_p: 2**REG_ADDR_W x DATA_W register file.
//   clk            : rising-edge clock
//   rst_n          : asynchronous active-low clear of every register
//   we/waddr/wdata : synchronous write port
//   raddr1/rdata1, raddr2/rdata2 : combinational read ports
// A write is visible on the read ports from the cycle after the write edge.
module cpu_regfile_p #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2
);

  localparam int NREG = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] regs_r [NREG];

  // Register storage: async clear, single synchronous write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (we) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata1 = regs_r[raddr1];
  assign rdata2 = regs_r[raddr2];

endmodule

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle core, FETCH -> DECODE -> EXEC -> WB.
//   CLK, RESET      : rising-edge clock, asynchronous active-low reset
//   PC              : address of the instruction being fetched/executed
//   INSTR_REQ       : registered fetch request, held until INSTR_VALID
//   INSTR_VALID     : instruction word valid (only looked at in FETCH)
//   INSTRUCTION     : [31:24] opcode, [23:16] dest/offset, [15:8] src1,
//                     [7:0] src2/imm
//   RETIRE          : one-cycle pulse in the WB cycle of every instruction
//   WB_EN/ADDR/DATA : register write, valid in the WB cycle only; ADDR and
//                     DATA hold their last value otherwise
// Optional feature macro: CPU_SHIFT_EN adds sll/srl/sra/ror (08..0B).
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int PC_W       = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic [PC_W-1:0]       PC,
  output logic                  INSTR_REQ,
  input  logic                  INSTR_VALID,
  input  logic [31:0]           INSTRUCTION,
  output logic                  RETIRE,
  output logic                  WB_EN,
  output logic [REG_ADDR_W-1:0] WB_ADDR,
  output logic [DATA_W-1:0]     WB_DATA
);

  localparam int SH_W = $clog2(DATA_W);

  state_e                state_r;
  logic [PC_W-1:0]       pc_r;
  logic [31:0]           instr_r;
  logic [DATA_W-1:0]     op_a_r;
  logic [DATA_W-1:0]     op_b_r;
  logic                  taken_r;
  logic                  req_r;
  logic                  retire_r;
  logic                  wb_en_r;
  logic [REG_ADDR_W-1:0] wb_addr_r;
  logic [DATA_W-1:0]     wb_data_r;

  dec_t                  dec_s;
  logic [DATA_W-1:0]     rdata1_s;
  logic [DATA_W-1:0]     rdata2_s;
  logic [DATA_W-1:0]     imm_s;
  logic [DATA_W-1:0]     b_eff_s;
  logic [2*DATA_W-1:0]   rot_s;
  logic [SH_W-1:0]       shamt_s;
  logic [DATA_W-1:0]     alu_s;
  logic [PC_W-1:0]       br_off_s;
  logic [PC_W-1:0]       pc_seq_s;
  logic [PC_W-1:0]       pc_next_s;
  logic                  unused_s;

  assign dec_s   = decode_op(instr_r[OPC_LSB +: FIELD_W]);
  assign imm_s   = DATA_W'(instr_r[SRC2_LSB +: FIELD_W]);
  // Shift ops carry the immediate in operand b; only its low bits matter.
  assign shamt_s = op_b_r[SH_W-1:0];
  // Register indices use only the low bits of each field.
  assign unused_s = &{1'b0, instr_r};

  cpu_regfile_p #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clk    (CLK),
    .rst_n  (RESET),
    .we     (wb_en_r),
    .waddr  (wb_addr_r),
    .wdata  (wb_data_r),
    .raddr1 (instr_r[SRC1_LSB +: REG_ADDR_W]),
    .raddr2 (instr_r[SRC2_LSB +: REG_ADDR_W]),
    .rdata1 (rdata1_s),
    .rdata2 (rdata2_s)
  );

  // ALU: subtraction is addition of the two's complement of operand b.
  always_comb begin
    b_eff_s = op_b_r;
    rot_s   = {op_a_r, op_a_r} >> shamt_s;
    alu_s   = op_b_r;
    if (dec_s.sub) begin
      b_eff_s = ~op_b_r + DATA_W'(1'b1);
    end else begin
      b_eff_s = op_b_r;
    end
    case (dec_s.alu_op)
      ALU_FWD: alu_s = op_b_r;
      ALU_ADD: alu_s = op_a_r + b_eff_s;
      ALU_AND: alu_s = op_a_r & op_b_r;
      ALU_OR:  alu_s = op_a_r | op_b_r;
      ALU_SHL: alu_s = op_a_r << shamt_s;
      ALU_SHR: alu_s = op_a_r >> shamt_s;
      ALU_SRA: alu_s = $signed(op_a_r) >>> shamt_s;
      ALU_ROR: alu_s = rot_s[DATA_W-1:0];
      default: alu_s = op_b_r;
    endcase
  end

  // Next PC: sequential, or relative with a sign-extended word offset.
  always_comb begin
    br_off_s = {{(PC_W-FIELD_W-2){instr_r[DST_LSB+FIELD_W-1]}},
                instr_r[DST_LSB +: FIELD_W], 2'b00};
    pc_seq_s = pc_r + PC_W'(32'd4);
    if (dec_s.jump || (dec_s.branch && taken_r)) begin
      pc_next_s = pc_seq_s + br_off_s;
    end else begin
      pc_next_s = pc_seq_s;
    end
  end

  // Sequencer FSM with registered outputs; WB controls are set on the
  // EXEC edge so they are high exactly during the WB cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r   <= ST_FETCH;
      pc_r      <= '0;
      instr_r   <= 32'h0000_0000;
      op_a_r    <= '0;
      op_b_r    <= '0;
      taken_r   <= 1'b0;
      req_r     <= 1'b0;
      retire_r  <= 1'b0;
      wb_en_r   <= 1'b0;
      wb_addr_r <= '0;
      wb_data_r <= '0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          // Accept only while the request is visible to memory.
          if (req_r && INSTR_VALID) begin
            instr_r <= INSTRUCTION;
            req_r   <= 1'b0;
            state_r <= ST_DECODE;
          end else begin
            req_r   <= 1'b1;
          end
        end
        ST_DECODE: begin
          op_a_r  <= rdata1_s;
          op_b_r  <= dec_s.use_imm ? imm_s : rdata2_s;
          state_r <= ST_EXEC;
        end
        ST_EXEC: begin
          taken_r  <= (op_a_r == op_b_r);
          retire_r <= 1'b1;
          if (dec_s.wr) begin
            wb_en_r   <= 1'b1;
            wb_addr_r <= instr_r[DST_LSB +: REG_ADDR_W];
            wb_data_r <= alu_s;
          end
          state_r <= ST_WB;
        end
        ST_WB: begin
          retire_r <= 1'b0;
          wb_en_r  <= 1'b0;
          pc_r     <= pc_next_s;
          req_r    <= 1'b1;
          state_r  <= ST_FETCH;
        end
        default: begin
          state_r <= ST_FETCH;
        end
      endcase
    end
  end

  assign PC        = pc_r;
  assign INSTR_REQ = req_r;
  assign RETIRE    = retire_r;
  assign WB_EN     = wb_en_r;
  assign WB_ADDR   = wb_addr_r;
  assign WB_DATA   = wb_data_r;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Self-checking bench for cpu_multicycle (DATA_W=8, 8 registers, PC_W=32).
// Instructions are supplied on demand at each fetch; a register/PC model
// computed from the instruction semantics predicts every retirement.
module tb_cpu_multicycle;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] PC;
  logic        INSTR_REQ;
  logic        INSTR_VALID = 1'b0;
  logic [31:0] INSTRUCTION = 32'h0;
  logic        RETIRE;
  logic        WB_EN;
  logic [2:0]  WB_ADDR;
  logic [7:0]  WB_DATA;

  cpu_multicycle dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC          (PC),
    .INSTR_REQ   (INSTR_REQ),
    .INSTR_VALID (INSTR_VALID),
    .INSTRUCTION (INSTRUCTION),
    .RETIRE      (RETIRE),
    .WB_EN       (WB_EN),
    .WB_ADDR     (WB_ADDR),
    .WB_DATA     (WB_DATA)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_regs [8];
  logic [31:0] m_pc;
  int          m_wb_addr;
  int          m_wb_data;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int d, input int s1, input int s2);
    return {op[7:0], d[7:0], s1[7:0], s2[7:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_pc = 32'h0;
    m_wb_addr = 0;
    m_wb_data = 0;
  endtask

  // Architectural effect of one instruction on the model state.
  task automatic model_step(input logic [31:0] ins, output bit wr, output int wa, output int wd);
    int opc, a, b, imm, sh, soff, sa;
    logic [31:0] step;
    opc  = int'(ins[31:24]);
    a    = m_regs[ins[10:8]];
    b    = m_regs[ins[2:0]];
    imm  = int'(ins[7:0]);
    sh   = imm % 8;
    wa   = int'(ins[18:16]);
    soff = ins[23] ? int'(ins[23:16]) - 256 : int'(ins[23:16]);
    wr   = 1'b1;
    wd   = 0;
    step = 32'd4;
    case (opc)
      0: wd = imm;
      1: wd = b;
      2: wd = (a + b) % 256;
      3: wd = (a - b + 256) % 256;
      4: wd = a & b;
      5: wd = a | b;
      6: begin wr = 1'b0; step = 32'(4 + 4 * soff); end
      7: begin wr = 1'b0; if (a == b) step = 32'(4 + 4 * soff); end
`ifdef CPU_SHIFT_EN
      8: wd = (a << sh) % 256;
      9: wd = a >> sh;
      10: begin sa = (a >= 128) ? a - 256 : a; wd = (sa >>> sh) & 255; end
      11: wd = ((a >> sh) | (a << (8 - sh))) & 255;
`endif
      default: wr = 1'b0;
    endcase
    if (wr) m_regs[wa] = wd;
    m_pc = m_pc + step;
  endtask

  task automatic do_reset(input bit chk);
    RESET = 1'b0;
    INSTR_VALID = 1'b0;
    @(negedge CLK);
    if (chk) begin
      check_val("rst_pc", PC, 32'h0);
      check_val("rst_req", INSTR_REQ, 1'b0);
      check_val("rst_retire", RETIRE, 1'b0);
      check_val("rst_wb_en", WB_EN, 1'b0);
      check_val("rst_wb_addr", WB_ADDR, 3'd0);
      check_val("rst_wb_data", WB_DATA, 8'h00);
    end
    @(negedge CLK);
    RESET = 1'b1;
    model_reset();
  endtask

  // Wait for the request, optionally stall, then hand over one word.
  task automatic fetch_phase(input logic [31:0] ins, input int stall);
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
      if (INSTR_REQ !== 1'b1) begin
        check_val("idle_retire", RETIRE, 1'b0);
        check_val("idle_wb_en", WB_EN, 1'b0);
      end
    end while (INSTR_REQ !== 1'b1 && k < 20);
    check_val("fetch_req", INSTR_REQ, 1'b1);
    check_val("fetch_pc", PC, m_pc);
    check_val("fetch_retire", RETIRE, 1'b0);
    for (int s = 0; s < stall; s++) begin
      @(negedge CLK);
      check_val("stall_req", INSTR_REQ, 1'b1);
      check_val("stall_pc", PC, m_pc);
      check_val("stall_retire", RETIRE, 1'b0);
    end
    INSTR_VALID = 1'b1;
    INSTRUCTION = ins;
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    INSTRUCTION = $urandom;
    check_val("req_drop", INSTR_REQ, 1'b0);
  endtask

  // From DECODE to WB: garbage on the fetch port must be ignored.
  task automatic complete(input logic [31:0] ins);
    bit wr;
    int wa, wd;
    int k = 1;
    logic [31:0] pc_now;
    pc_now = m_pc;
    model_step(ins, wr, wa, wd);
    while (RETIRE !== 1'b1 && k < 10) begin
      check_val("pre_wb_en", WB_EN, 1'b0);
      INSTR_VALID = 1'($urandom_range(0, 1));
      INSTRUCTION = $urandom;
      @(negedge CLK);
      k++;
    end
    INSTR_VALID = 1'b0;
    check_val("latency", k, 3);
    check_val("retire", RETIRE, 1'b1);
    check_val("wb_en", WB_EN, wr);
    if (wr) begin
      m_wb_addr = wa;
      m_wb_data = wd;
    end
    check_val("wb_addr", WB_ADDR, m_wb_addr);
    check_val("wb_data", WB_DATA, m_wb_data);
    check_val("wb_pc", PC, pc_now);
  endtask

  task automatic run_instr(input logic [31:0] ins, input int stall);
    fetch_phase(ins, stall);
    complete(ins);
  endtask

  initial begin
    model_reset();
    #1;
    do_reset(1'b1);

    // Basic arithmetic sequence
    run_instr(mk(0, 1, 0, 5), 0);
    run_instr(mk(0, 2, 0, 3), 0);
    run_instr(mk(2, 3, 1, 2), 0);
    check_val("t1_add", WB_DATA, 8'h08);
    run_instr(mk(3, 4, 1, 2), 0);
    check_val("t1_sub", WB_DATA, 8'h02);
    @(negedge CLK);
    check_val("t1_pc", PC, 32'd16);

    // 8-bit wrap on sub and add
    run_instr(mk(0, 1, 0, 0), 0);
    run_instr(mk(0, 2, 0, 1), 0);
    run_instr(mk(3, 3, 1, 2), 0);
    check_val("t2_sub_wrap", WB_DATA, 8'hFF);
    run_instr(mk(2, 4, 3, 2), 0);
    check_val("t2_add_wrap", WB_DATA, 8'h00);

    // Branches and jumps
    do_reset(1'b0);
    run_instr(mk(0, 1, 0, 7), 0);
    run_instr(mk(0, 2, 0, 9), 0);
    run_instr(mk(7, 2, 1, 1), 0);
    @(negedge CLK);
    check_val("t3_beq_taken", PC, 32'd20);
    run_instr(mk(6, 8'hFE, 0, 0), 0);
    @(negedge CLK);
    check_val("t3_j_back", PC, 32'd16);
    run_instr(mk(7, 2, 1, 2), 0);
    @(negedge CLK);
    check_val("t3_beq_not", PC, 32'd20);

    // Fetch stall
    run_instr(mk(0, 6, 0, 8'hA5), 10);

    // Reset during EXEC aborts the instruction
    fetch_phase(mk(2, 3, 1, 2), 0);
    @(negedge CLK);
    check_val("t5_exec_wb_en", WB_EN, 1'b0);
    #2 RESET = 1'b0;
    #1;
    check_val("t5_pc", PC, 32'h0);
    check_val("t5_wb_en", WB_EN, 1'b0);
    check_val("t5_req", INSTR_REQ, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    model_reset();
    run_instr(mk(1, 5, 0, 3), 0);
    check_val("t5_r3_zero", WB_DATA, 8'h00);

    // Shift opcodes (NOP when the feature is absent)
    run_instr(mk(0, 1, 0, 8'h81), 0);
    for (int op = 8; op <= 11; op++) begin
      run_instr(mk(op, op - 6, 1, 1), 0);
    end

    // Random programs
    for (int n = 0; n < 150; n++) begin
      int op;
      op = $urandom_range(0, 13);
      if ($urandom_range(0, 9) == 0) op = 8'hFF;
      run_instr(mk(op, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)),
                $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
